// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the fetch stage: FSM state encoding,
// datapath width, and the reset/increment values used for the program counter.
package pc_fetch_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INC_DEF   = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, load of a redirect
// target (priority) or a word-addressed increment that wraps modulo 2^32.
module pc_reg
  import pc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [WORD_W-1:0] target_i,
  output logic [WORD_W-1:0] pc_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: issues instruction-memory reads at the PC and hands words to
// decode over valid/ready. Optional feature macro: FETCH_BYPASS_EN (refetch from HOLD).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_MXPC,
  input  logic              W_PC,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] ir_out,
  output logic [WORD_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [WORD_W-1:0] out_ADD
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] ir_out_q, ir_out_d;
  logic [WORD_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              redir_pend_q, redir_pend_d;
  logic [WORD_W-1:0] redir_tgt_q, redir_tgt_d;
  logic              drop_q, drop_d;

  logic              pc_load;
  logic              pc_inc;
  logic [WORD_W-1:0] pc_tgt;
  logic [WORD_W-1:0] pc;
  logic              req;
  logic              transfer;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pc_load),
    .inc_i    (pc_inc),
    .target_i (pc_tgt),
    .pc_o     (pc)
  );

  assign transfer = ir_valid_q && ir_ready;

  always_comb begin
    state_d      = state_q;
    ir_out_d     = ir_out_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    drop_d       = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_tgt       = in_MXPC;
    req          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        pc_load = W_PC;
      end

      ST_REQ: begin
        if (drop_q) begin
          // One idle cycle after a discarded response; the new address goes out next.
          pc_load = W_PC;
        end else begin
          req = 1'b1;
          if (imem_ready) begin
            if (redir_pend_q || W_PC) begin
              pc_load      = 1'b1;
              pc_tgt       = W_PC ? in_MXPC : redir_tgt_q;
              redir_pend_d = 1'b0;
              drop_d       = 1'b1;
            end else begin
              ir_out_d   = imem_data;
              ir_pc_d    = pc;
              ir_valid_d = 1'b1;
              pc_inc     = 1'b1;
              state_d    = ST_HOLD;
            end
          end else if (W_PC) begin
            // The access in flight cannot be cancelled; remember where to go instead.
            redir_pend_d = 1'b1;
            redir_tgt_d  = in_MXPC;
          end
        end
      end

      ST_HOLD: begin
`ifdef FETCH_BYPASS_EN
        req = ir_ready && !W_PC;
        if (W_PC) begin
          pc_load    = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (transfer) begin
          if (imem_ready) begin
            ir_out_d   = imem_data;
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
            pc_inc     = 1'b1;
          end else begin
            ir_valid_d = 1'b0;
            state_d    = ST_REQ;
          end
        end
`else
        if (W_PC) begin
          pc_load    = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (transfer) begin
          ir_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ir_out_q     <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_out_q     <= ir_out_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      drop_q       <= drop_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc;
  assign ir_out    = ir_out_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign out_ADD   = ir_pc_q + PC_INC;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed stimulus pushes expected deliveries,
// a monitor pops and compares on every decode transfer.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_MXPC;
  logic        W_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] out_ADD;

  pc_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .in_MXPC    (in_MXPC),
    .W_PC       (W_PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .ir_out     (ir_out),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .out_ADD    (out_ADD)
  );

  always #5 clk = ~clk;

`ifdef FETCH_BYPASS_EN
  localparam int EXP_SPAN = 5;
`else
  localparam int EXP_SPAN = 10;
`endif

  // Memory: answers after 'lat' cycles of asserted request; 'stale' injects a bogus response.
  int        lat;
  logic      stale;
  logic [7:0] cnt;
  logic      mem_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (!imem_req || mem_rdy) cnt <= '0;
    else cnt <= cnt + 8'd1;
  end

  assign mem_rdy    = imem_req && (int'(cnt) >= lat);
  assign imem_ready = mem_rdy || stale;
  assign imem_data  = stale ? 32'hDEAD_BEEF : imem_addr + 32'h0000_A000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] add;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_first = -1;
  int   t_last = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] d, input logic [31:0] a);
    exp_t e;
    e.pc = p; e.data = d; e.add = a;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && ir_valid && ir_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got ir_pc %h expected no transfer", ir_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ir_pc", ir_pc, e.pc);
        chk("ir_out", ir_out, e.data);
        chk("out_ADD", out_ADD, e.add);
        if (e.pc == 32'hFFFF_FFFF) t_first = cyc;
        if (e.pc == 32'h0000_0004) t_last = cyc;
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget && sb.size() != 0; i++) step();
    if (sb.size() != 0) tmo(name);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i;
    for (i = 0; i < budget && !ir_valid; i++) step();
    if (!ir_valid) tmo(name);
  endtask

  initial begin
    rst = 1'b1; W_PC = 1'b0; in_MXPC = '0; ir_ready = 1'b0; stale = 1'b0; lat = 2;
    #12;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir_out", ir_out, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_out_ADD", out_ADD, 32'h1);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Sequential fetch, L=2, decode always ready
    push(32'h0, 32'h0000_A000, 32'h1);
    push(32'h1, 32'h0000_A001, 32'h2);
    push(32'h2, 32'h0000_A002, 32'h3);
    ir_ready = 1'b1;
    step();
    rst = 1'b0;
    wait_drain("seq_drain", 60);

    // Backpressure: hold the next instruction for 5 cycles
    ir_ready = 1'b0;
    push(32'h3, 32'h0000_A003, 32'h4);
    wait_valid("bp_valid", 30);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ir_out", ir_out, 32'h0000_A003);
      chk("bp_ir_pc", ir_pc, 32'h3);
      chk("bp_imem_req", {31'd0, imem_req}, 32'd0);
      chk("bp_ir_valid", {31'd0, ir_valid}, 32'd1);
      step();
    end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    chk("bp_released", {31'd0, ir_valid}, 32'd0);

    // Async reset mid-request with response pending
    step();
    #3 rst = 1'b1;
    #1;
    chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("arst_ir_pc", ir_pc, 32'h0);
    chk("arst_ir_out", ir_out, 32'h0);
    chk("arst_out_ADD", out_ADD, 32'h1);
    lat = 3;
    stale = 1'b1;
    step();
    rst = 1'b0;
    step();
    stale = 1'b0;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_stale", {31'd0, ir_valid}, 32'd0);

    // Redirect while the request at addr 0 is outstanding (L=3)
    step();
    W_PC = 1'b1; in_MXPC = 32'h40;
    step();
    W_PC = 1'b0;
    chk("redir_valid_c2", {31'd0, ir_valid}, 32'd0);
    step();
    chk("redir_valid_c3", {31'd0, ir_valid}, 32'd0);
    chk("redir_req_held", {31'd0, imem_req}, 32'd1);
    chk("redir_addr_held", imem_addr, 32'h0);
    step();
    chk("redir_valid_c4", {31'd0, ir_valid}, 32'd0);
    chk("redir_req_drop", {31'd0, imem_req}, 32'd0);
    step();
    chk("redir_req_again", {31'd0, imem_req}, 32'd1);
    chk("redir_new_addr", imem_addr, 32'h40);
    push(32'h40, 32'h0000_A040, 32'h41);

    // Simultaneous W_PC and transfer in HOLD
    wait_valid("hold_valid", 30);
    ir_ready = 1'b1; W_PC = 1'b1; in_MXPC = 32'h80;
    push(32'h80, 32'h0000_A080, 32'h81);
    step();
    W_PC = 1'b0;
    chk("hold_redir_clear", {31'd0, ir_valid}, 32'd0);
    wait_drain("hold_drain", 60);

    // Wrap-around and throughput at L=0
    ir_ready = 1'b0; lat = 0; W_PC = 1'b1; in_MXPC = 32'hFFFF_FFFF;
    push(32'hFFFF_FFFF, 32'h0000_9FFF, 32'h0000_0000);
    push(32'h0000_0000, 32'h0000_A000, 32'h0000_0001);
    push(32'h0000_0001, 32'h0000_A001, 32'h0000_0002);
    push(32'h0000_0002, 32'h0000_A002, 32'h0000_0003);
    push(32'h0000_0003, 32'h0000_A003, 32'h0000_0004);
    push(32'h0000_0004, 32'h0000_A004, 32'h0000_0005);
    step();
    W_PC = 1'b0; ir_ready = 1'b1;
    wait_drain("wrap_drain", 100);
    ir_ready = 1'b0;
    chk("wrap_span", t_last - t_first, EXP_SPAN);

    repeat (4) step();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
